// File: rtl/rvseed_seq_if.sv
// Instruction-memory bus between the rvseed sequencer and instruction memory.
//   imem_req_o    : fetch request (sequencer -> memory)
//   imem_gnt_i    : request accepted (memory -> sequencer)
//   imem_rvalid_i : read data valid (memory -> sequencer)
//   imem_rdata_i  : instruction word (memory -> sequencer)
// Signal names carry the sequencer's point of view.
interface rvseed_seq_if #(
    parameter int CPU_WIDTH = 32
);
    logic                 imem_req_o;
    logic                 imem_gnt_i;
    logic                 imem_rvalid_i;
    logic [CPU_WIDTH-1:0] imem_rdata_i;

    modport master (
        output imem_req_o,
        input  imem_gnt_i,
        input  imem_rvalid_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        output imem_gnt_i,
        output imem_rvalid_i,
        output imem_rdata_i
    );
endinterface

// File: rtl/rvseed_seq.sv
// Multi-cycle instruction sequencer for the rvseed core.
// Fetches one instruction at a time over the imem bus, latches it for decode,
// and opens a single EXEC cycle in which the PC advances and the register
// file may be written. Provides run / halt / single-step control, a fetch
// timeout that parks the sequencer in ERR, and a retired-instruction counter.
//   clk, rst        : core clock, asynchronous active-high reset
//   run_i           : free-run level
//   step_i          : single-step pulse (honoured only while halted)
//   halt_req_i      : halt after the in-flight instruction
//   imem            : instruction-memory bus (master side)
//   inst_o          : latched instruction word
//   inst_valid_o    : instruction valid (EXEC)
//   pc_ena_o        : PC register enable (EXEC)
//   reg_wen_i/_o    : register-file write enable, gated to EXEC
//   halted_o, err_o : status
//   retire_cnt_o    : retired-instruction count, wraps silently
module rvseed_seq #(
    parameter int CPU_WIDTH = 32,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run_i,
    input  logic                 step_i,
    input  logic                 halt_req_i,
    rvseed_seq_if.master         imem,
    output logic [CPU_WIDTH-1:0] inst_o,
    output logic                 inst_valid_o,
    output logic                 pc_ena_o,
    input  logic                 reg_wen_i,
    output logic                 reg_wen_o,
    output logic                 halted_o,
    output logic                 err_o,
    output logic [31:0]          retire_cnt_o
);

    typedef enum logic [2:0] {
        S_HALT  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_EXEC  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t               state, state_n;
    logic [7:0]           tmo_cnt;
    logic                 single_step;
    logic                 halt_pend;
    logic [CPU_WIDTH-1:0] inst;
    logic [31:0]          retire_cnt;
    logic                 tmo_hit;

    assign tmo_hit = (tmo_cnt == TMO_LAST);

    // Next-state logic. A pending transition always wins over the timeout.
    always_comb begin
        state_n = state;
        case (state)
            // step_i bypasses a held halt_req_i; run_i does not.
            S_HALT:  if (step_i || (run_i && !halt_req_i)) state_n = S_FETCH;
            S_FETCH: if (imem.imem_gnt_i)                  state_n = S_WAIT;
                     else if (tmo_hit)                     state_n = S_ERR;
            S_WAIT:  if (imem.imem_rvalid_i)               state_n = S_EXEC;
                     else if (tmo_hit)                     state_n = S_ERR;
            S_EXEC:  if (single_step || halt_pend || halt_req_i || !run_i)
                         state_n = S_HALT;
                     else
                         state_n = S_FETCH;
            S_ERR:   state_n = S_ERR;
            default: state_n = S_HALT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_HALT;
        end else begin
            state <= state_n;
        end
    end

    // Timeout counter spans FETCH and WAIT of one instruction; the
    // FETCH->WAIT hop does not restart it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state_n == S_FETCH && state != S_FETCH) begin
            tmo_cnt <= '0;
        end else if (state == S_FETCH || state == S_WAIT) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    // Control flags live for exactly one instruction and clear on leaving EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            single_step <= 1'b0;
            halt_pend   <= 1'b0;
        end else begin
            if (state == S_HALT && step_i)
                single_step <= 1'b1;
            else if (state == S_EXEC)
                single_step <= 1'b0;

            if ((state == S_FETCH || state == S_WAIT) && halt_req_i)
                halt_pend <= 1'b1;
            else if (state == S_EXEC)
                halt_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst       <= '0;
            retire_cnt <= '0;
        end else begin
            if (state == S_WAIT && imem.imem_rvalid_i)
                inst <= imem.imem_rdata_i;
            if (state == S_EXEC)
                retire_cnt <= retire_cnt + 32'd1;
        end
    end

    // Everything is decoded from state so reset drops the request at once.
    assign imem.imem_req_o = (state == S_FETCH);
    assign inst_o          = inst;
    assign inst_valid_o    = (state == S_EXEC);
    assign pc_ena_o        = (state == S_EXEC);
    assign reg_wen_o       = reg_wen_i && (state == S_EXEC);
    assign halted_o        = (state == S_HALT);
    assign err_o           = (state == S_ERR);
    assign retire_cnt_o    = retire_cnt;

endmodule
